// File: rtl/fifo_flag_gen_param.sv
// -----------------------------------------------------------------------------
// fifo_flag_gen_param
//
// Registered flag generator for a single-clock FIFO. Works out the occupancy
// from binary read/write indices plus their wrap-phase bits, and registers
// ptr_diff together with the full / empty / almost_full / almost_empty flags.
// DEPTH does not have to be a power of two.
//
// Almost-full and almost-empty thresholds can be programmed at runtime.
// Overflow, underflow and illegal-pointer errors are sticky until clr_err.
//
// Optional build macro: FIFO_FLAG_WATERMARK_EN
//   Adds a high-watermark register (output hwm) and its reload input (hwm_clr).
//
// Ports
//   clk, reset_n          : rising-edge clock, synchronous active-low reset
//   b_wr_ptr, wr_phase    : write index (0..DEPTH-1) and its wrap phase
//   b_rd_ptr, rd_phase    : read index (0..DEPTH-1) and its wrap phase
//   wr_en, rd_en          : request strobes; used only to detect errors
//   cfg_we                : loads cfg_af_thr / cfg_ae_thr (clamped to DEPTH)
//   clr_err               : clears the sticky error flags
//   hwm_clr, hwm          : watermark reload / value (macro builds only)
//   ptr_diff              : registered occupancy
//   full, empty           : occupancy == DEPTH / occupancy == 0
//   almost_full           : occupancy >= af threshold
//   almost_empty          : occupancy <= ae threshold
//   overflow, underflow   : sticky request errors
//   ptr_err               : sticky illegal-pointer-pair error
// -----------------------------------------------------------------------------
module fifo_flag_gen_param #(
  parameter int A_LENGTH   = 3,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int AF_DEFAULT = DEPTH - 1,
  parameter int AE_DEFAULT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [A_LENGTH-1:0] b_wr_ptr,
  input  logic                wr_phase,
  input  logic [A_LENGTH-1:0] b_rd_ptr,
  input  logic                rd_phase,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic                cfg_we,
  input  logic [CNT_W-1:0]    cfg_af_thr,
  input  logic [CNT_W-1:0]    cfg_ae_thr,
  input  logic                clr_err,
`ifdef FIFO_FLAG_WATERMARK_EN
  input  logic                hwm_clr,
  output logic [CNT_W-1:0]    hwm,
`endif
  output logic [CNT_W-1:0]    ptr_diff,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow,
  output logic                ptr_err
);

  // The arithmetic width covers both the pointer width and DEPTH itself, plus
  // one spare bit, so nothing is truncated before the comparisons.
  localparam int AW = ((A_LENGTH > CNT_W) ? A_LENGTH : CNT_W) + 1;
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  // Clamp a programmed threshold to DEPTH.
  function automatic logic [CNT_W-1:0] sat_thr(input logic [CNT_W-1:0] v);
    return (v > L_DEPTH) ? L_DEPTH : v;
  endfunction

  logic [CNT_W-1:0] r_ptr_diff;
  logic             r_full, r_empty, r_af, r_ae;
  logic             r_ovf, r_unf, r_perr;
  logic [CNT_W-1:0] r_af_thr, r_ae_thr;

  logic [AW-1:0] w_wr, w_rd, w_depth, w_d_ext, w_d;
  logic          w_same_ph, w_bad;

  assign w_wr      = AW'(b_wr_ptr);
  assign w_rd      = AW'(b_rd_ptr);
  assign w_depth   = AW'(DEPTH);
  assign w_same_ph = (wr_phase == rd_phase);

  // A pointer pair is illegal when either index is out of range, or when the
  // order of the indices disagrees with the phase relationship.
  assign w_bad = (w_wr >= w_depth) || (w_rd >= w_depth) ||
                 ( w_same_ph && (w_wr < w_rd)) ||
                 (!w_same_ph && (w_wr > w_rd));

  // When the phases differ, the write index has wrapped once more than the
  // read index. Equal indices then mean the FIFO is full (d = DEPTH).
  assign w_d_ext = w_same_ph ? (w_wr - w_rd) : (w_depth - w_rd + w_wr);
  assign w_d     = w_bad ? AW'(r_ptr_diff) : w_d_ext;

  // ---- registered stage: occupancy, flags, thresholds, sticky errors ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr_diff <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= 1'b0;
      r_ae       <= 1'b1;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_perr     <= 1'b0;
      r_af_thr   <= CNT_W'(AF_DEFAULT);
      r_ae_thr   <= CNT_W'(AE_DEFAULT);
    end else begin
      r_ptr_diff <= w_d[CNT_W-1:0];
      r_full     <= (w_d == w_depth);
      r_empty    <= (w_d == '0);
      // The flags use the thresholds that were in force before this edge.
      r_af       <= (w_d >= AW'(r_af_thr));
      r_ae       <= (w_d <= AW'(r_ae_thr));
      if (cfg_we) begin
        r_af_thr <= sat_thr(cfg_af_thr);
        r_ae_thr <= sat_thr(cfg_ae_thr);
      end
      // Errors are judged against the registered flags. A new set condition
      // wins over clr_err on the same edge.
      r_ovf  <= (wr_en && r_full && !rd_en) || (r_ovf  && !clr_err);
      r_unf  <= (rd_en && r_empty)          || (r_unf  && !clr_err);
      r_perr <= w_bad                       || (r_perr && !clr_err);
    end
  end

`ifdef FIFO_FLAG_WATERMARK_EN
  logic [CNT_W-1:0] r_hwm;

  // Reloading with the current level rather than zero means the present
  // occupancy is always included in the watermark.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hwm <= '0;
    end else if (hwm_clr) begin
      r_hwm <= w_d[CNT_W-1:0];
    end else if (w_d > AW'(r_hwm)) begin
      r_hwm <= w_d[CNT_W-1:0];
    end
  end

  assign hwm = r_hwm;
`endif

  assign ptr_diff     = r_ptr_diff;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign ptr_err      = r_perr;

endmodule

// File: tb/tb_fifo_flag_gen_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_flag_gen_param
//
// Directed bench for fifo_flag_gen_param. It drives two instances: u8
// (DEPTH=8) and u6 (DEPTH=6). Both use A_LENGTH=3 and share the pointer and
// request inputs. Each section checks only the instance it targets. Inputs
// change 1 ns after a rising edge, and outputs are read at that same point.
// -----------------------------------------------------------------------------
module tb_fifo_flag_gen_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [2:0] wp, rp;
  logic       wph, rph;
  logic       wr_en, rd_en, clr_err, cfg_we;
  logic [3:0] cfg_af, cfg_ae;

  logic [3:0] pd8;
  logic       full8, empty8, af8, ae8, ovf8, unf8, perr8;
  logic [2:0] pd6;
  logic       full6, empty6, af6, ae6, ovf6, unf6, perr6;

`ifdef FIFO_FLAG_WATERMARK_EN
  logic       hwm_clr;
  logic [3:0] hwm8;
  logic [2:0] hwm6;
`endif

  fifo_flag_gen_param #(.A_LENGTH(3), .DEPTH(8)) u8 (
    .clk(clk), .reset_n(reset_n),
    .b_wr_ptr(wp), .wr_phase(wph), .b_rd_ptr(rp), .rd_phase(rph),
    .wr_en(wr_en), .rd_en(rd_en),
    .cfg_we(cfg_we), .cfg_af_thr(cfg_af), .cfg_ae_thr(cfg_ae),
    .clr_err(clr_err),
`ifdef FIFO_FLAG_WATERMARK_EN
    .hwm_clr(hwm_clr), .hwm(hwm8),
`endif
    .ptr_diff(pd8), .full(full8), .empty(empty8),
    .almost_full(af8), .almost_empty(ae8),
    .overflow(ovf8), .underflow(unf8), .ptr_err(perr8)
  );

  fifo_flag_gen_param #(.A_LENGTH(3), .DEPTH(6)) u6 (
    .clk(clk), .reset_n(reset_n),
    .b_wr_ptr(wp), .wr_phase(wph), .b_rd_ptr(rp), .rd_phase(rph),
    .wr_en(wr_en), .rd_en(rd_en),
    .cfg_we(1'b0), .cfg_af_thr(3'd0), .cfg_ae_thr(3'd0),
    .clr_err(clr_err),
`ifdef FIFO_FLAG_WATERMARK_EN
    .hwm_clr(hwm_clr), .hwm(hwm6),
`endif
    .ptr_diff(pd6), .full(full6), .empty(empty6),
    .almost_full(af6), .almost_empty(ae6),
    .overflow(ovf6), .underflow(unf6), .ptr_err(perr6)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input int w, input int w_ph, input int r, input int r_ph);
    wp  = 3'(w);
    wph = w_ph[0];
    rp  = 3'(r);
    rph = r_ph[0];
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; cfg_we = 1'b0;
    cfg_af = '0; cfg_ae = '0;
`ifdef FIFO_FLAG_WATERMARK_EN
    hwm_clr = 1'b0;
`endif
    set_ptr(0, 0, 0, 0);

    // Reset state.
    tick(); tick();
    check("rst_pd",   pd8,   0);
    check("rst_empty", empty8, 1);
    check("rst_ae",   ae8,   1);
    check("rst_full", full8, 0);
    check("rst_af",   af8,   0);
    check("rst_ovf",  ovf8,  0);
    check("rst_unf",  unf8,  0);
    check("rst_perr", perr8, 0);
    reset_n = 1'b1;

    // Fill the DEPTH=6 instance. almost_full defaults to a threshold of 5.
    for (int k = 1; k <= 6; k++) begin
      if (k < 6) set_ptr(k, 0, 0, 0);
      else       set_ptr(0, 1, 0, 0);
      tick();
      check($sformatf("fill_pd%0d", k),   pd6,   k);
      check($sformatf("fill_full%0d", k), full6, (k == 6) ? 1 : 0);
      check($sformatf("fill_af%0d", k),   af6,   (k >= 5) ? 1 : 0);
    end

    // Wrapped difference: 6 - 4 + 2 = 4.
    set_ptr(2, 1, 4, 0); tick();
    check("wrap_pd",   pd6,   4);
    check("wrap_perr", perr6, 0);
    // Phases differ but wr > rd: illegal, so ptr_diff holds.
    set_ptr(4, 0, 2, 1); tick();
    check("ill_ph_pd",   pd6,   4);
    check("ill_ph_perr", perr6, 1);
    clr_err = 1'b1; set_ptr(2, 1, 4, 0); tick(); clr_err = 1'b0;
    check("clr_perr", perr6, 0);
    // Index out of range (6 >= DEPTH).
    set_ptr(6, 0, 0, 0); tick();
    check("oor_pd",   pd6,   4);
    check("oor_perr", perr6, 1);
    // Same phase with wr < rd, together with clr_err: the set wins.
    clr_err = 1'b1; set_ptr(1, 0, 3, 0); tick(); clr_err = 1'b0;
    check("setwin_perr", perr6, 1);
    check("setwin_pd",   pd6,   4);

    // Thresholds on the DEPTH=8 instance.
    reset_n = 1'b0; set_ptr(0, 0, 0, 0); tick(); reset_n = 1'b1;
    set_ptr(3, 0, 0, 0); tick();
    check("thr_pd3", pd8, 3);
    check("thr_af_before", af8, 0);
    cfg_we = 1'b1; cfg_af = 4'd3; cfg_ae = 4'd2; tick(); cfg_we = 1'b0;
    check("thr_af_loadedge", af8, 0);
    tick();
    check("thr_af_next", af8, 1);
    check("thr_ae_next", ae8, 0);
    set_ptr(2, 0, 0, 0); tick();
    check("thr_ae_d2", ae8, 1);
    check("thr_af_d2", af8, 0);
    cfg_we = 1'b1; cfg_af = 4'd9; cfg_ae = 4'd8; tick(); cfg_we = 1'b0;
    set_ptr(7, 0, 0, 0); tick();
    check("clamp_af_d7", af8, 0);
    check("clamp_ae_d7", ae8, 1);
    set_ptr(0, 1, 0, 0); tick();
    check("clamp_pd8",   pd8,   8);
    check("clamp_full",  full8, 1);
    check("clamp_af_d8", af8,   1);
    check("clamp_ae_d8", ae8,   1);
    cfg_we = 1'b1; cfg_af = 4'd0; cfg_ae = 4'd0; tick(); cfg_we = 1'b0;
    set_ptr(0, 0, 0, 0); tick();
    check("af0_af",    af8,    1);
    check("af0_empty", empty8, 1);
    check("af0_ae",    ae8,    1);

    // Sticky errors.
    set_ptr(0, 1, 0, 0); tick();
    check("err_full", full8, 1);
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    check("ovf_set", ovf8, 1);
    clr_err = 1'b1; wr_en = 1'b1; tick(); clr_err = 1'b0; wr_en = 1'b0;
    check("ovf_setwin", ovf8, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clr", ovf8, 0);
    wr_en = 1'b1; rd_en = 1'b1; tick(); wr_en = 1'b0; rd_en = 1'b0;
    check("ovf_wr_rd", ovf8, 0);
    set_ptr(0, 0, 0, 0); tick();
    check("err_empty", empty8, 1);
    check("unf_idle",  unf8,   0);
    rd_en = 1'b1; wr_en = 1'b1; tick(); rd_en = 1'b0; wr_en = 1'b0;
    check("unf_set", unf8, 1);
    set_ptr(1, 0, 3, 0); tick();
    check("perr8_set", perr8, 1);
    check("perr8_pd",  pd8,   0);
    set_ptr(0, 1, 0, 0); tick();
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    check("all_ovf",  ovf8,  1);
    check("all_unf",  unf8,  1);
    check("all_perr", perr8, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_ovf",  ovf8,  0);
    check("clr_unf",  unf8,  0);
    check("clr_perr8", perr8, 0);

    // Reset arriving mid-operation overrides a pending overflow and a bad pair.
    wr_en = 1'b1; set_ptr(1, 0, 3, 0); reset_n = 1'b0; tick();
    reset_n = 1'b1; wr_en = 1'b0; set_ptr(0, 0, 0, 0);
    check("midrst_ovf",   ovf8,   0);
    check("midrst_perr",  perr8,  0);
    check("midrst_empty", empty8, 1);
    check("midrst_af",    af8,    0);

`ifdef FIFO_FLAG_WATERMARK_EN
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("hwm_rst", hwm6, 0);
    for (int k = 1; k <= 5; k++) begin
      set_ptr(k, 0, 0, 0); tick();
    end
    set_ptr(5, 0, 3, 0); tick();
    check("hwm_peak", hwm6, 5);
    check("hwm_pd2",  pd6,  2);
    hwm_clr = 1'b1; tick(); hwm_clr = 1'b0;
    check("hwm_reload", hwm6, 2);
    set_ptr(5, 0, 2, 0); tick();
    check("hwm_refill", hwm6, 3);
    check("hwm8_refill", hwm8, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
